rho_inv_seq: RTL and testbench

- Multi-cycle inverse of the Keccak rho step.
- Takes a 1600-bit state (5x5 lanes, 64 bits each) on a valid/ready handshake.
- Rotates each lane right by its rho offset mod 64, one plane (fixed y, all 5 x) per cycle, then presents the result on a valid/ready output.
- Used by the permutation-engine verification/unwind path and by any decryption-style step that must undo rho.

---
 rtl/keccak_pkg.sv | 33 +++
 rtl/lane_rotr.sv | 29 ++
 rtl/rho_inv_seq.sv | 113 +++++++++++
 tb/tb_rho_inv_seq.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keccak_pkg.sv
// Shared Keccak types, the rho offset table and the rho-unwind FSM states.
// Types: lane_t, state_t; RHO_OFFSET[x][y] raw 9-bit; rho_amt() gives mod 64.
package keccak_pkg;

  typedef logic [63:0] lane_t;
  typedef logic [4:0][4:0][63:0] state_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } rho_inv_state_e;

  localparam logic [8:0] RHO_OFFSET [5][5] = '{
    '{9'd0,   9'd36,  9'd3,   9'd105, 9'd210},
    '{9'd1,   9'd300, 9'd10,  9'd45,  9'd66 },
    '{9'd190, 9'd6,   9'd171, 9'd15,  9'd253},
    '{9'd28,  9'd55,  9'd153, 9'd21,  9'd120},
    '{9'd91,  9'd276, 9'd231, 9'd136, 9'd78 }
  };

  // Plane indices 5-7 never occur in normal use; they map to no rotation.
  function automatic logic [5:0] rho_amt(
    input int         x,
    input logic [2:0] y
  );
    logic [8:0] raw;
    raw = 9'd0;
    if (y < 3'd5) raw = RHO_OFFSET[x][y];
    return raw[5:0];
  endfunction

endpackage

// File: rtl/lane_rotr.sv
// Combinational 64-bit lane rotator, right by amt (left when dir=1).
// Ports: din, amt[5:0], dir (RHO_DIR_EN builds only), dout.
module lane_rotr
  import keccak_pkg::*;
(
  input  lane_t      din,
  input  logic [5:0] amt,
`ifdef RHO_DIR_EN
  input  logic       dir,
`endif
  output lane_t      dout
);

  logic [6:0] inv_amt;
  lane_t      rotr;

  // A shift by 64 yields zero, so amt=0 needs no special case.
  assign inv_amt = 7'd64 - {1'b0, amt};
  assign rotr    = (din >> amt) | (din << inv_amt);

`ifdef RHO_DIR_EN
  lane_t rotl;
  assign rotl = (din << amt) | (din >> inv_amt);
  assign dout = dir ? rotl : rotr;
`else
  assign dout = rotr;
`endif

endmodule

// File: rtl/rho_inv_seq.sv
// Multi-cycle inverse Keccak rho: one plane (fixed y) rotated per cycle.
// Ports: clk, rst_n, in_valid/in_ready/in_state, out_valid/out_ready/
// out_state, busy; dir when RHO_DIR_EN is defined (1 = forward rho).
module rho_inv_seq
  import keccak_pkg::*;
#(
  parameter int LANE_W = 64,
  parameter int PLANES = 5
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   in_valid,
  output logic   in_ready,
  input  state_t in_state,
`ifdef RHO_DIR_EN
  input  logic   dir,
`endif
  output logic   out_valid,
  input  logic   out_ready,
  output state_t out_state,
  output logic   busy
);

  if (LANE_W != 64) begin : g_lane_chk
    $error("rho_inv_seq: LANE_W must be 64");
  end

  localparam logic [2:0] LAST = 3'(PLANES - 1);

  rho_inv_state_e st_q;
  state_t         work_q;
  logic [2:0]     y_q;
  lane_t [4:0]    rot;

`ifdef RHO_DIR_EN
  logic dir_q;
`endif

  for (genvar gx = 0; gx < 5; gx++) begin : g_rot
    lane_rotr u_rot (
      .din  (work_q[gx][y_q]),
      .amt  (rho_amt(gx, y_q)),
`ifdef RHO_DIR_EN
      .dir  (dir_q),
`endif
      .dout (rot[gx])
    );
  end

  assign out_state = work_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= IDLE;
      work_q    <= '0;
      y_q       <= 3'd0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef RHO_DIR_EN
      dir_q     <= 1'b0;
`endif
    end else begin
      unique case (st_q)
        IDLE: begin
          if (in_valid) begin
            work_q   <= in_state;
            y_q      <= 3'd0;
            st_q     <= BUSY;
            in_ready <= 1'b0;
            busy     <= 1'b1;
`ifdef RHO_DIR_EN
            dir_q    <= dir;
`endif
          end
        end
        BUSY: begin
          if (y_q > LAST) begin
            // Corrupted counter: abandon and return to idle.
            y_q      <= 3'd0;
            st_q     <= IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end else begin
            for (int x = 0; x < 5; x++) begin
              work_q[x][y_q] <= rot[x];
            end
            y_q <= y_q + 3'd1;
            if (y_q == LAST) begin
              st_q      <= DONE;
              out_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            st_q      <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          st_q      <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rho_inv_seq.sv
// Scoreboard bench for rho_inv_seq: directed, round-trip, backpressure,
// reset-abort and back-to-back cases.
module tb_rho_inv_seq;
  import keccak_pkg::*;

  logic   clk = 1'b0;
  logic   rst_n;
  logic   in_valid;
  logic   in_ready;
  state_t in_state;
  logic   out_valid;
  logic   out_ready;
  state_t out_state;
  logic   busy;
`ifdef RHO_DIR_EN
  logic   dir;
`endif

  rho_inv_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
`ifdef RHO_DIR_EN
    .dir       (dir),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int OFFT [5][5] = '{
    '{0,   1,   190, 28,  91 },
    '{36,  300, 6,   55,  276},
    '{3,   10,  171, 153, 231},
    '{105, 45,  15,  21,  136},
    '{210, 66,  253, 120, 78 }
  };

  int     n_cmp = 0;
  int     n_bad = 0;
  int     cyc = 0;
  int     acc_cnt = 0;
  int     ov_seen = 0;
  int     acc_t[$];
  state_t exp_q[$];
  state_t cur_exp;

  always @(posedge clk) cyc++;

  function automatic state_t fwd(state_t s);
    state_t r;
    int o;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++) begin
        o = OFFT[y][x] % 64;
        for (int z = 0; z < 64; z++)
          r[x][y][z] = s[x][y][(z - o + 64) % 64];
      end
    return r;
  endfunction

  function automatic state_t rnd_state();
    state_t r;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        r[x][y] = {$urandom, $urandom};
    return r;
  endfunction

  task automatic chk_state(string nm, state_t act, state_t exp);
    bit shown;
    shown = 1'b0;
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      for (int x = 0; x < 5; x++)
        for (int y = 0; y < 5; y++)
          if (!shown && act[x][y] !== exp[x][y]) begin
            shown = 1'b1;
            $display("FAIL %s lane[%0d][%0d] got %h want %h",
                     nm, x, y, act[x][y], exp[x][y]);
          end
    end
  endtask

  task automatic chk_int(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_bit(string nm, logic act, logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got %b want %b", nm, act, exp);
    end
  endtask

  // Input acceptance: expected response is queued at the handshake.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      exp_q.push_back(cur_exp);
      acc_cnt++;
      acc_t.push_back(cyc);
    end
  end

  // Output monitor: compare each delivered result against the queue head.
  always @(negedge clk) begin
    if (rst_n && out_valid) ov_seen++;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output got valid want none");
      end else begin
        chk_state("result", out_state, exp_q.pop_front());
      end
    end
  end

  task automatic send(input state_t s, input state_t e);
    int a0;
    bit ok;
    a0 = acc_cnt;
    ok = 1'b0;
    in_state = s;
    cur_exp  = e;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (acc_cnt != a0) begin
        ok = 1'b1;
        break;
      end
    end
    #1 in_valid = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout got none want accept");
    end
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout got %0d pending want 0", exp_q.size());
    end
  endtask

  initial begin
    state_t s;
    state_t e;
    state_t o;
    state_t bb [3];
    int     lat;
    int     a0;
    int     ov0;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_state  = '0;
    cur_exp   = '0;
    out_ready = 1'b1;
`ifdef RHO_DIR_EN
    dir = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_bit("rst_in_ready", in_ready, 1'b1);
    chk_bit("rst_out_valid", out_valid, 1'b0);
    chk_bit("rst_busy", busy, 1'b0);
    chk_state("rst_out_state", out_state, '0);

    // Single bit at [1][0][0], OFF=1 -> [1][0][63]; latency 6 edges.
    s = '0;
    s[1][0][0] = 1'b1;
    e = '0;
    e[1][0][63] = 1'b1;
    send(s, e);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk_bit("busy_high", busy, 1'b1);
        chk_bit("busy_in_ready", in_ready, 1'b0);
      end
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    chk_int("latency", lat, 6);
    wait_drain();

    // OFF 276 -> 20; lane [0][0] has offset 0.
    s = '0;
    s[4][1] = 64'h1 << 20;
    s[0][0] = 64'hDEADBEEF_01234567;
    e = '0;
    e[4][1] = 64'h1;
    e[0][0] = 64'hDEADBEEF_01234567;
    send(s, e);
    wait_drain();

    // Round trip through the forward model.
    for (int i = 0; i < 100; i++) begin
      o = rnd_state();
      send(fwd(o), o);
    end
    wait_drain();

`ifdef RHO_DIR_EN
    dir = 1'b1;
    for (int i = 0; i < 10; i++) begin
      o = rnd_state();
      send(o, fwd(o));
    end
    wait_drain();
    dir = 1'b0;
`endif

    // Backpressure: result must hold, no accept while stalled.
    out_ready = 1'b0;
    o = rnd_state();
    send(fwd(o), o);
    for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
    a0 = acc_cnt;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      in_valid = (i == 4);
      if (i == 4) begin
        in_state = rnd_state();
        cur_exp  = rnd_state();
      end
      @(negedge clk);
      chk_state("bp_hold", out_state, o);
      chk_bit("bp_in_ready", in_ready, 1'b0);
      chk_bit("bp_out_valid", out_valid, 1'b1);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk_int("bp_no_accept", acc_cnt, a0);
    out_ready = 1'b1;
    wait_drain();
    repeat (10) @(negedge clk);
    chk_int("bp_no_late_accept", acc_cnt, a0);

    // Reset during the third BUSY cycle.
    o = rnd_state();
    send(fwd(o), o);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk_bit("abort_out_valid", out_valid, 1'b0);
    chk_bit("abort_busy", busy, 1'b0);
    chk_bit("abort_in_ready", in_ready, 1'b1);
    chk_state("abort_out_state", out_state, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    ov0 = ov_seen;
    repeat (12) @(negedge clk);
    chk_int("abort_no_output", ov_seen - ov0, 0);
    chk_bit("abort_ready_after", in_ready, 1'b1);

    // Back-to-back with in_valid and out_ready held high.
    acc_t.delete();
    for (int i = 0; i < 3; i++) bb[i] = rnd_state();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a0 = acc_cnt;
      in_state = fwd(bb[i]);
      cur_exp  = bb[i];
      for (int k = 0; k < 30; k++) begin
        @(posedge clk);
        if (acc_cnt != a0) break;
      end
      #1;
    end
    in_valid = 1'b0;
    wait_drain();
    chk_int("b2b_accepts", acc_t.size(), 3);
    if (acc_t.size() == 3) begin
      chk_int("b2b_gap0", acc_t[1] - acc_t[0], 7);
      chk_int("b2b_gap1", acc_t[2] - acc_t[1], 7);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
